fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32 core. Owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register. It consumes the redirect decision (PcSel, BrPC, HaltSel) that the execute-stage branch logic produces, and runs a halt-drain sequence so that in-flight instructions retire before the core reports halted.

## Interface
- PC_W, 9: program-counter width in bits; byte address, word aligned.
- DRAIN_CYCLES, 3: cycles spent in HALT_DRAIN before Halted asserts; legal range 1..15.
- NOP, 32'h0000_0013: instruction word loaded into IF/ID on flush or bubble.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous and active-low (0 = reset).
- Stall  in  1  hazard hold; freezes PC and IF/ID.
- PcSel  in  1  redirect request from execute stage.
- BrPC  in  32  redirect target; bits [PC_W-1:0] used, upper bits ignored.
- HaltSel  in  1  halt request from execute stage; valid only together with PcSel.
- Instr  in  32  instruction-memory read data for Pc_Out, combinational, same cycle.
- Pc_Out  out  PC_W  current fetch address (the PC register).
- IfId_PC  out  PC_W  PC of the instruction held in IF/ID.
- IfId_Instr  out  32  instruction held in IF/ID.
- IfId_Valid  out  1  IF/ID holds a real instruction.
- Halted  out  1  sticky; core halted.
- MisalignErr  out  1  sticky; a redirect target had BrPC[1:0] != 0.
- FetchCount  out  32  number of valid instructions loaded into IF/ID.

## Operation
- FSM states: RUN, HALT_DRAIN, HALTED. Reset state is RUN.
- Reset values: Pc_Out 0, IfId_PC 0, IfId_Instr NOP, IfId_Valid 0, Halted 0, MisalignErr 0, FetchCount 0, drain counter 0.
- RUN priority, highest first:
  - PcSel && HaltSel:
    - PC <= {BrPC[PC_W-1:2], 2'b00}.
    - IF/ID flushed: IfId_Instr NOP, IfId_Valid 0, IfId_PC 0.
    - Drain counter <= DRAIN_CYCLES-1.
    - Next state HALT_DRAIN.
  - PcSel: PC <= {BrPC[PC_W-1:2], 2'b00}; IF/ID flushed as above. Redirect overrides Stall.
  - Stall: PC, IF/ID and FetchCount hold.
  - Otherwise:
    - PC <= PC + 4, modulo 2^PC_W; the maximum word address wraps to 0.
    - IfId_PC <= PC, IfId_Instr <= Instr, IfId_Valid <= 1.
    - FetchCount increments, wrapping at 2^32.
- HALTED, SEEN WITHOUT PcSel: HaltSel without PcSel is ignored.
- MisalignErr sets on any accepted redirect with BrPC[1:0] != 0, including a halt redirect. It clears only on reset.
- HALT_DRAIN:
  - PC holds; IF/ID stays flushed.
  - PcSel, HaltSel and Stall are ignored.
  - Drain counter decrements each cycle. When it is 0, next state is HALTED.
- HALTED: all registers hold, Halted = 1, inputs ignored. Only reset exits.
- Reset asserted in any state, mid-drain included: all registers return to their reset values at that edge.

## Timing
- Pc_Out is the registered PC. Instr is sampled at the same edge that advances the PC.
- Fetch latency: instruction at address A is on Pc_Out in cycle N and appears in IF/ID in cycle N+1.
- First cycle after reset release:
  - Pc_Out = 0 and IfId_Valid = 0.
  - The next edge loads the word at 0 with IfId_Valid 1.
- Redirect:
  - PcSel high in cycle N gives Pc_Out = target and IfId_Valid = 0 in cycle N+1 (one bubble).
  - The target instruction is in IF/ID in cycle N+2, unless Stall is high in N+1.
- Halt:
  - Request in cycle N gives HALT_DRAIN in cycles N+1 .. N+DRAIN_CYCLES.
  - Halted rises in cycle N+DRAIN_CYCLES+1.
- Stall held k cycles: outputs are frozen for exactly k cycles. No instruction is lost or duplicated.

## Test plan
- Reset then 4 free-run cycles with imem[i] = 0x100+i: IfId_PC steps 0, 4, 8 and IF/ID shows the matching words; FetchCount = 3 after the third load.
- Stall high for 2 cycles while Pc_Out = 8: Pc_Out stays 8 and IF/ID stays at PC 4 for both cycles. After release, the PC 8 instruction appears next cycle with no duplicate.
- PcSel with BrPC = 0x40 while Pc_Out = 0x10:
  - Next cycle Pc_Out = 0x40, IfId_Valid = 0, IfId_Instr = 0x00000013.
  - The following cycle IfId_PC = 0x40.
- PcSel and Stall high together with BrPC = 0x80: the redirect wins, Pc_Out = 0x80 next cycle, FetchCount unchanged.
- PcSel with HaltSel and BrPC = 0x20, DRAIN_CYCLES = 3:
  - Halted rises exactly 4 cycles later; Pc_Out stays 0x20.
  - Later PcSel pulses have no effect.
  - Reset asserted during drain returns Pc_Out to 0, Halted to 0, state to RUN.
- BrPC = 0x1FE with PC_W = 9: Pc_Out = 0x1FC and MisalignErr = 1. The next free-run step wraps Pc_Out to 0x000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the fetch stage's bus-side signals: the redirect/halt decision
//   from execute, the hazard stall, the instruction-memory address/data
//   pair and the IF/ID pipeline register outputs with status.
//   master : the surrounding core (drives Stall/PcSel/BrPC/HaltSel/Instr)
//   slave  : the fetch stage (drives Pc_Out, IF/ID and status outputs)
interface fetch_stage_if #(
   parameter int PC_W = 9
);
   logic            Stall;
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            HaltSel;
   logic [31:0]     Instr;
   logic [PC_W-1:0] Pc_Out;
   logic [PC_W-1:0] IfId_PC;
   logic [31:0]     IfId_Instr;
   logic            IfId_Valid;
   logic            Halted;
   logic            MisalignErr;
   logic [31:0]     FetchCount;

   modport master (
      output Stall, PcSel, BrPC, HaltSel, Instr,
      input  Pc_Out, IfId_PC, IfId_Instr, IfId_Valid, Halted, MisalignErr, FetchCount
   );

   modport slave (
      input  Stall, PcSel, BrPC, HaltSel, Instr,
      output Pc_Out, IfId_PC, IfId_Instr, IfId_Valid, Halted, MisalignErr, FetchCount
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32 core. Owns the PC, drives
//   the instruction-memory address, registers the fetched word into IF/ID,
//   applies execute-stage redirects and runs a halt-drain sequence before
//   reporting Halted.
//   clk   : rising-edge clock
//   reset : synchronous, active-low (0 = reset)
//   bus   : fetch_stage_if.slave (Stall, PcSel, BrPC, HaltSel, Instr in;
//           Pc_Out, IfId_PC, IfId_Instr, IfId_Valid, Halted, MisalignErr,
//           FetchCount out)
module fetch_stage #(
   parameter int          PC_W         = 9,
   parameter int          DRAIN_CYCLES = 3,
   parameter logic [31:0] NOP          = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     fetch_count_q, fetch_count_d;
   logic [3:0]      drain_q, drain_d;
   logic            halted;

   // Upper redirect bits beyond the PC width are intentionally dropped.
   logic unused_brpc_hi;
   assign unused_brpc_hi = ^bus.BrPC[31:PC_W];

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= RUN;
         pc_q          <= '0;
         ifid_pc_q     <= '0;
         ifid_instr_q  <= NOP;
         ifid_valid_q  <= 1'b0;
         misalign_q    <= 1'b0;
         fetch_count_q <= '0;
         drain_q       <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_valid_q  <= ifid_valid_d;
         misalign_q    <= misalign_d;
         fetch_count_q <= fetch_count_d;
         drain_q       <= drain_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_valid_d  = ifid_valid_q;
      misalign_d    = misalign_q;
      fetch_count_d = fetch_count_q;
      drain_d       = drain_q;

      case (state_q)
         RUN: begin
            if (bus.PcSel) begin
               // Redirect beats Stall; target forced word aligned, the
               // dropped low bits are flagged sticky.
               pc_d         = {bus.BrPC[PC_W-1:2], 2'b00};
               ifid_pc_d    = '0;
               ifid_instr_d = NOP;
               ifid_valid_d = 1'b0;
               if (bus.BrPC[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end
               if (bus.HaltSel) begin
                  drain_d = 4'(DRAIN_CYCLES - 1);
                  state_d = HALT_DRAIN;
               end
            end else if (!bus.Stall) begin
               pc_d          = pc_q + PC_W'(4);
               ifid_pc_d     = pc_q;
               ifid_instr_d  = bus.Instr;
               ifid_valid_d  = 1'b1;
               fetch_count_d = fetch_count_q + 32'd1;
            end
         end
         HALT_DRAIN: begin
            // IF/ID was flushed on entry and simply holds here.
            if (drain_q == 4'd0) begin
               state_d = HALTED;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Output logic
   always_comb begin
      halted = (state_q == HALTED);
   end

   assign bus.Pc_Out      = pc_q;
   assign bus.IfId_PC     = ifid_pc_q;
   assign bus.IfId_Instr  = ifid_instr_q;
   assign bus.IfId_Valid  = ifid_valid_q;
   assign bus.Halted      = halted;
   assign bus.MisalignErr = misalign_q;
   assign bus.FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam int PC_W = 9;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   fetch_stage_if #(.PC_W(PC_W)) bus ();

   fetch_stage #(.PC_W(PC_W), .DRAIN_CYCLES(3), .NOP(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Instruction memory: imem[i] = 0x100 + i, combinational read.
   logic [31:0] pc_ext;
   assign pc_ext    = {{(32-PC_W){1'b0}}, bus.Pc_Out};
   assign bus.Instr = 32'h100 + (pc_ext >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge, then settle before sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      bus.Stall   = 1'b0;
      bus.PcSel   = 1'b0;
      bus.HaltSel = 1'b0;
      bus.BrPC    = 32'h0;

      step();
      step();
      chk("rst_pc", 32'(bus.Pc_Out), 32'h0);
      chk("rst_valid", 32'(bus.IfId_Valid), 32'h0);
      chk("rst_instr", bus.IfId_Instr, NOP);
      chk("rst_halted", 32'(bus.Halted), 32'h0);
      chk("rst_misalign", 32'(bus.MisalignErr), 32'h0);
      chk("rst_count", bus.FetchCount, 32'h0);

      // Free run
      reset = 1'b1;
      step();
      chk("run1_ifpc", 32'(bus.IfId_PC), 32'h0);
      chk("run1_instr", bus.IfId_Instr, 32'h100);
      chk("run1_valid", 32'(bus.IfId_Valid), 32'h1);
      chk("run1_pc", 32'(bus.Pc_Out), 32'h4);
      step();
      chk("run2_ifpc", 32'(bus.IfId_PC), 32'h4);
      chk("run2_instr", bus.IfId_Instr, 32'h101);
      chk("run2_pc", 32'(bus.Pc_Out), 32'h8);

      // Stall two cycles with Pc_Out = 8
      bus.Stall = 1'b1;
      step();
      chk("stall1_pc", 32'(bus.Pc_Out), 32'h8);
      chk("stall1_ifpc", 32'(bus.IfId_PC), 32'h4);
      chk("stall1_count", bus.FetchCount, 32'd2);
      step();
      chk("stall2_pc", 32'(bus.Pc_Out), 32'h8);
      chk("stall2_ifpc", 32'(bus.IfId_PC), 32'h4);
      chk("stall2_instr", bus.IfId_Instr, 32'h101);
      bus.Stall = 1'b0;
      step();
      chk("rel_ifpc", 32'(bus.IfId_PC), 32'h8);
      chk("rel_instr", bus.IfId_Instr, 32'h102);
      chk("rel_count", bus.FetchCount, 32'd3);
      step();
      chk("run4_pc", 32'(bus.Pc_Out), 32'h10);
      chk("run4_count", bus.FetchCount, 32'd4);

      // Redirect to 0x40 while Pc_Out = 0x10
      bus.PcSel = 1'b1;
      bus.BrPC  = 32'h40;
      step();
      bus.PcSel = 1'b0;
      chk("redir_pc", 32'(bus.Pc_Out), 32'h40);
      chk("redir_valid", 32'(bus.IfId_Valid), 32'h0);
      chk("redir_instr", bus.IfId_Instr, NOP);
      chk("redir_count", bus.FetchCount, 32'd4);
      step();
      chk("redir_tgt_ifpc", 32'(bus.IfId_PC), 32'h40);
      chk("redir_tgt_instr", bus.IfId_Instr, 32'h110);
      chk("redir_tgt_pc", 32'(bus.Pc_Out), 32'h44);
      chk("redir_tgt_count", bus.FetchCount, 32'd5);

      // Redirect with Stall: redirect wins
      bus.PcSel = 1'b1;
      bus.Stall = 1'b1;
      bus.BrPC  = 32'h80;
      step();
      bus.PcSel = 1'b0;
      bus.Stall = 1'b0;
      chk("rs_pc", 32'(bus.Pc_Out), 32'h80);
      chk("rs_count", bus.FetchCount, 32'd5);
      chk("rs_valid", 32'(bus.IfId_Valid), 32'h0);
      chk("rs_misalign", 32'(bus.MisalignErr), 32'h0);

      // Misaligned target and PC wrap
      bus.PcSel = 1'b1;
      bus.BrPC  = 32'h1FE;
      step();
      bus.PcSel = 1'b0;
      chk("mis_pc", 32'(bus.Pc_Out), 32'h1FC);
      chk("mis_err", 32'(bus.MisalignErr), 32'h1);
      step();
      chk("wrap_pc", 32'(bus.Pc_Out), 32'h0);
      chk("wrap_ifpc", 32'(bus.IfId_PC), 32'h1FC);
      chk("wrap_instr", bus.IfId_Instr, 32'h17F);
      chk("wrap_count", bus.FetchCount, 32'd6);

      // Halt redirect to 0x20, DRAIN_CYCLES = 3
      bus.PcSel   = 1'b1;
      bus.HaltSel = 1'b1;
      bus.BrPC    = 32'h20;
      step();
      bus.PcSel   = 1'b0;
      bus.HaltSel = 1'b0;
      chk("h1_pc", 32'(bus.Pc_Out), 32'h20);
      chk("h1_halted", 32'(bus.Halted), 32'h0);
      chk("h1_valid", 32'(bus.IfId_Valid), 32'h0);
      // Redirect during drain is ignored
      bus.PcSel = 1'b1;
      bus.BrPC  = 32'h60;
      step();
      bus.PcSel = 1'b0;
      chk("h2_halted", 32'(bus.Halted), 32'h0);
      chk("h2_pc", 32'(bus.Pc_Out), 32'h20);
      step();
      chk("h3_halted", 32'(bus.Halted), 32'h0);
      step();
      chk("h4_halted", 32'(bus.Halted), 32'h1);
      chk("h4_pc", 32'(bus.Pc_Out), 32'h20);
      chk("h4_misalign", 32'(bus.MisalignErr), 32'h1);
      bus.PcSel = 1'b1;
      bus.BrPC  = 32'h40;
      step();
      bus.PcSel = 1'b0;
      chk("hd_pc", 32'(bus.Pc_Out), 32'h20);
      chk("hd_halted", 32'(bus.Halted), 32'h1);
      chk("hd_count", bus.FetchCount, 32'd6);
      step();
      chk("hd2_valid", 32'(bus.IfId_Valid), 32'h0);

      // Reset out of HALTED, then reset in the middle of a drain
      reset = 1'b0;
      step();
      chk("rh_halted", 32'(bus.Halted), 32'h0);
      reset = 1'b1;
      step();
      chk("rh_pc", 32'(bus.Pc_Out), 32'h4);
      bus.PcSel   = 1'b1;
      bus.HaltSel = 1'b1;
      bus.BrPC    = 32'h20;
      step();
      bus.PcSel   = 1'b0;
      bus.HaltSel = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("rd_pc", 32'(bus.Pc_Out), 32'h0);
      chk("rd_halted", 32'(bus.Halted), 32'h0);
      chk("rd_count", bus.FetchCount, 32'h0);
      chk("rd_misalign", 32'(bus.MisalignErr), 32'h0);
      reset = 1'b1;
      step();
      chk("rr_pc", 32'(bus.Pc_Out), 32'h4);
      chk("rr_valid", 32'(bus.IfId_Valid), 32'h1);
      step();
      step();
      step();
      chk("rr_run_pc", 32'(bus.Pc_Out), 32'h10);
      chk("rr_run_halted", 32'(bus.Halted), 32'h0);
      chk("rr_run_count", bus.FetchCount, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
